// File: rtl/fp_div_seq.sv
// fp_div_seq: sequential divider for the 22-bit float format
//   (s[21], e[20:16] bias 15, f[15:0] unsigned 1.15 with f[15]=1).
//   Radix-2 restoring division of the mantissas, fixed 18-cycle latency,
//   one operation in flight.
// Ports:
//   clk, rst          clock, asynchronous active-high reset
//   i_start           request, accepted only while o_busy==0
//   i_a, i_b          dividend / divisor, sampled on the accepting edge
//   o_busy            high from the accepting edge until the o_valid edge
//   o_valid           one-cycle pulse, o_c / o_div0 valid
//   o_c               quotient, held until the next o_valid
//   o_div0            divisor was zero, held with o_c
module fp_div_seq (
  input  logic        clk,
  input  logic        rst,
  input  logic        i_start,
  input  logic [21:0] i_a,
  input  logic [21:0] i_b,
  output logic        o_busy,
  output logic        o_valid,
  output logic [21:0] o_c,
  output logic        o_div0
);

  localparam int unsigned FW       = 16;  // mantissa width
  localparam int unsigned EW       = 5;   // exponent width
  localparam int unsigned XW       = 7;   // signed working exponent width
  localparam int unsigned CW       = 5;   // iteration counter width
  localparam int unsigned BIAS     = 15;
  localparam logic [CW-1:0] LAST_CNT = CW'(16);

  typedef enum logic [1:0] {S_IDLE, S_CALC, S_NORM} state_t;

  state_t               r_state, w_state_nxt;
  logic                 r_sign, w_sign_nxt;
  logic signed [XW-1:0] r_exp_t, w_exp_nxt;
  logic [FW:0]          r_rem, w_rem_nxt;
  logic [FW-1:0]        r_den, w_den_nxt;
  logic [FW:0]          r_quo, w_quo_nxt;
  logic [CW-1:0]        r_cnt, w_cnt_nxt;
  logic                 r_a_zero, w_a_zero_nxt;
  logic                 r_b_zero, w_b_zero_nxt;
  logic                 w_busy_nxt, w_valid_nxt, w_div0_nxt;
  logic [21:0]          w_c_nxt;

  logic                 w_ge;
  logic [FW:0]          w_diff, w_sub;
  logic signed [XW-1:0] w_exp_fin;
  logic [21:0]          w_sat;

  // One restoring step: trial subtract of the divisor from the partial remainder
  assign w_ge   = r_rem >= {1'b0, r_den};
  assign w_diff = r_rem - {1'b0, r_den};
  assign w_sub  = w_ge ? w_diff : r_rem;

  // Quotient lies in (0.5, 2): drop one exponent when the integer bit is clear
  assign w_exp_fin = r_quo[FW] ? r_exp_t : r_exp_t - XW'(1);
  assign w_sat     = {r_sign, {EW{1'b1}}, {FW{1'b1}}};

  // Next-state and next-register values
  always_comb begin
    w_state_nxt  = r_state;
    w_sign_nxt   = r_sign;
    w_exp_nxt    = r_exp_t;
    w_rem_nxt    = r_rem;
    w_den_nxt    = r_den;
    w_quo_nxt    = r_quo;
    w_cnt_nxt    = r_cnt;
    w_a_zero_nxt = r_a_zero;
    w_b_zero_nxt = r_b_zero;
    w_busy_nxt   = o_busy;
    w_valid_nxt  = 1'b0;
    w_c_nxt      = o_c;
    w_div0_nxt   = o_div0;

    case (r_state)
      S_IDLE: begin
        if (i_start) begin
          w_sign_nxt   = i_a[21] ^ i_b[21];
          w_exp_nxt    = XW'({2'b00, i_a[20:16]}) - XW'({2'b00, i_b[20:16]}) + XW'(BIAS);
          w_rem_nxt    = {1'b0, i_a[FW-1:0]};
          w_den_nxt    = i_b[FW-1:0];
          w_quo_nxt    = '0;
          w_cnt_nxt    = '0;
          w_a_zero_nxt = (i_a[20:16] == '0);
          w_b_zero_nxt = (i_b[20:16] == '0);
          w_busy_nxt   = 1'b1;
          w_state_nxt  = S_CALC;
        end
      end

      S_CALC: begin
        w_quo_nxt = {r_quo[FW-1:0], w_ge};
        // Remainder after subtraction is below the divisor, so the top bit is free
        w_rem_nxt = {w_sub[FW-1:0], 1'b0};
        w_cnt_nxt = r_cnt + CW'(1);
        if (r_cnt == LAST_CNT) begin
          w_state_nxt = S_NORM;
        end
      end

      S_NORM: begin
        w_valid_nxt = 1'b1;
        w_busy_nxt  = 1'b0;
        w_div0_nxt  = 1'b0;
        w_state_nxt = S_IDLE;
        if (r_b_zero) begin
          w_c_nxt    = w_sat;
          w_div0_nxt = 1'b1;
        end else if (r_a_zero || (w_exp_fin <= 0)) begin
          w_c_nxt = '0;
        end else if (w_exp_fin >= XW'(31)) begin
          w_c_nxt = w_sat;
        end else begin
          w_c_nxt = {r_sign, w_exp_fin[EW-1:0],
                     r_quo[FW] ? r_quo[FW:1] : r_quo[FW-1:0]};
        end
      end

      default: begin
        w_state_nxt = S_IDLE;
        w_busy_nxt  = 1'b0;
      end
    endcase
  end

  // State and datapath registers
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_state  <= S_IDLE;
      r_sign   <= 1'b0;
      r_exp_t  <= '0;
      r_rem    <= '0;
      r_den    <= '0;
      r_quo    <= '0;
      r_cnt    <= '0;
      r_a_zero <= 1'b0;
      r_b_zero <= 1'b0;
      o_busy   <= 1'b0;
      o_valid  <= 1'b0;
      o_c      <= '0;
      o_div0   <= 1'b0;
    end else begin
      r_state  <= w_state_nxt;
      r_sign   <= w_sign_nxt;
      r_exp_t  <= w_exp_nxt;
      r_rem    <= w_rem_nxt;
      r_den    <= w_den_nxt;
      r_quo    <= w_quo_nxt;
      r_cnt    <= w_cnt_nxt;
      r_a_zero <= w_a_zero_nxt;
      r_b_zero <= w_b_zero_nxt;
      o_busy   <= w_busy_nxt;
      o_valid  <= w_valid_nxt;
      o_c      <= w_c_nxt;
      o_div0   <= w_div0_nxt;
    end
  end

endmodule

// File: tb/tb_fp_div_seq.sv
// tb_fp_div_seq: self-checking bench for fp_div_seq. Directed and random
//   divisions compared against an arithmetic reference model, plus
//   handshake, latency and mid-operation reset behaviour.
module tb_fp_div_seq;

  logic        clk = 1'b0;
  logic        rst;
  logic        i_start;
  logic [21:0] i_a;
  logic [21:0] i_b;
  logic        o_busy;
  logic        o_valid;
  logic [21:0] o_c;
  logic        o_div0;

  int n_checks = 0;
  int n_errors = 0;

  fp_div_seq dut (
    .clk     (clk),
    .rst     (rst),
    .i_start (i_start),
    .i_a     (i_a),
    .i_b     (i_b),
    .o_busy  (o_busy),
    .o_valid (o_valid),
    .o_c     (o_c),
    .o_div0  (o_div0)
  );

  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_errors++;
      $display("FAIL %s: got %h expected %h", tag, got, exp);
    end
  endtask

  // Reference: value = f/2^15 * 2^(e-15); quotient truncated to 16 mantissa bits
  function automatic logic [22:0] ref_div(input logic [21:0] a, input logic [21:0] b);
    int     ea, eb, e;
    longint fa, fb, q, frac;
    logic   s;
    ea = int'(a[20:16]);
    eb = int'(b[20:16]);
    fa = longint'(a[15:0]);
    fb = longint'(b[15:0]);
    s  = a[21] ^ b[21];
    if (eb == 0) return {1'b1, s, 5'h1f, 16'hffff};
    if (ea == 0) return 23'h0;
    q = (fa * 65536) / fb;
    if (q >= 65536) begin
      frac = q / 2;
      e    = ea - eb + 15;
    end else begin
      frac = q;
      e    = ea - eb + 14;
    end
    if (e <= 0)  return 23'h0;
    if (e >= 31) return {1'b0, s, 5'h1f, 16'hffff};
    return {1'b0, s, 5'(e), 16'(frac)};
  endfunction

  // One operation; optional start pulse mid-CALC that must be ignored
  task automatic run_op(input logic [21:0] a, input logic [21:0] b,
                        input bit poke_mid, input string tag);
    logic [22:0] exp_r;
    logic [21:0] held;
    int          n;
    bit          seen, stable, busy_ok;
    exp_r   = ref_div(a, b);
    held    = o_c;
    seen    = 0;
    stable  = 1;
    busy_ok = 1;
    n       = 0;
    @(negedge clk);
    i_a = a; i_b = b; i_start = 1'b1;
    @(posedge clk); #1;
    i_start = 1'b0;
    i_a = 22'($urandom);
    i_b = 22'($urandom);
    while (!seen && n < 40) begin
      @(posedge clk); #1;
      n++;
      if (o_valid) begin
        seen = 1;
      end else begin
        if (o_c !== held) stable = 0;
        if (o_busy !== 1'b1) busy_ok = 0;
      end
      if (poke_mid && n == 5) begin
        i_start = 1'b1; i_a = 22'h0F8000; i_b = 22'h0F8000;
      end
      if (poke_mid && n == 6) i_start = 1'b0;
    end
    check({tag, "_seen"}, 32'(seen), 32'd1);
    check({tag, "_lat"}, 32'(n), 32'd18);
    check({tag, "_c"}, 32'(o_c), 32'(exp_r[21:0]));
    check({tag, "_div0"}, 32'(o_div0), 32'(exp_r[22]));
    check({tag, "_stable"}, 32'(stable), 32'd1);
    check({tag, "_busy"}, 32'(busy_ok), 32'd1);
    @(posedge clk); #1;
    check({tag, "_pulse"}, 32'(o_valid), 32'd0);
    check({tag, "_idle"}, 32'(o_busy), 32'd0);
    check({tag, "_hold"}, 32'(o_c), 32'(exp_r[21:0]));
  endtask

  // Start held high across two operations: second accepted on the o_valid cycle
  task automatic run_b2b(input logic [21:0] a1, input logic [21:0] b1,
                         input logic [21:0] a2, input logic [21:0] b2);
    logic [22:0] e1, e2;
    int          n;
    e1 = ref_div(a1, b1);
    e2 = ref_div(a2, b2);
    @(negedge clk);
    i_a = a1; i_b = b1; i_start = 1'b1;
    @(posedge clk); #1;
    i_a = a2; i_b = b2;
    n = 0;
    do begin
      @(posedge clk); #1;
      n++;
    end while (!o_valid && n < 40);
    check("b2b_lat1", 32'(n), 32'd18);
    check("b2b_c1", 32'(o_c), 32'(e1[21:0]));
    n = 0;
    do begin
      @(posedge clk); #1;
      n++;
      if (n == 1) check("b2b_reaccept", 32'(o_busy), 32'd1);
    end while (!o_valid && n < 40);
    i_start = 1'b0;
    check("b2b_lat2", 32'(n), 32'd19);
    check("b2b_c2", 32'(o_c), 32'(e2[21:0]));
    @(posedge clk); #1;
    check("b2b_idle", 32'(o_busy), 32'd0);
  endtask

  task automatic run_reset_mid;
    bit pulsed;
    @(negedge clk);
    i_a = 22'h10C000; i_b = 22'h0F8000; i_start = 1'b1;
    @(posedge clk); #1;
    i_start = 1'b0;
    repeat (8) @(posedge clk);
    @(negedge clk);
    rst = 1'b1;
    #1;
    check("rst_busy", 32'(o_busy), 32'd0);
    check("rst_valid", 32'(o_valid), 32'd0);
    check("rst_c", 32'(o_c), 32'd0);
    check("rst_div0", 32'(o_div0), 32'd0);
    repeat (2) @(negedge clk);
    rst = 1'b0;
    pulsed = 0;
    repeat (25) begin
      @(posedge clk); #1;
      if (o_valid) pulsed = 1;
    end
    check("rst_no_valid", 32'(pulsed), 32'd0);
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    logic [21:0] ra, rb;
    rst = 1'b1; i_start = 1'b0; i_a = '0; i_b = '0;
    #12;
    check("reset_busy", 32'(o_busy), 32'd0);
    check("reset_valid", 32'(o_valid), 32'd0);
    check("reset_c", 32'(o_c), 32'd0);
    check("reset_div0", 32'(o_div0), 32'd0);
    @(negedge clk);
    rst = 1'b0;

    run_op(22'h0F8000, 22'h0F8000, 0, "one");
    run_op(22'h0F8000, 22'h10C000, 0, "third");
    run_op(22'h10C000, 22'h108000, 1, "three_half");
    run_op(22'h2F8000, 22'h0F8000, 0, "neg");
    run_op(22'h000000, 22'h0F8000, 0, "zero_a");
    run_op(22'h0F8000, 22'h000000, 0, "div0");
    run_op(22'h000000, 22'h200000, 0, "div0_both");
    run_op(22'h018000, 22'h1E8000, 0, "underflow");
    run_op(22'h3E8000, 22'h018000, 0, "saturate");

    run_b2b(22'h0F8000, 22'h10C000, 22'h2FFFFF, 22'h0E8001);
    run_reset_mid();
    run_op(22'h10C000, 22'h0F8000, 0, "after_rst");

    for (int i = 0; i < 40; i++) begin
      ra = {1'($urandom), ($urandom_range(0, 9) == 0) ? 5'd0 : 5'($urandom_range(1, 31)),
            1'b1, 15'($urandom)};
      rb = {1'($urandom), ($urandom_range(0, 9) == 0) ? 5'd0 : 5'($urandom_range(1, 31)),
            1'b1, 15'($urandom)};
      run_op(ra, rb, (i % 4) == 0, $sformatf("rnd%0d", i));
    end

    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
    $finish;
  end

endmodule
